// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: default operand width and FSM encoding.
package serial_adder_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Request/response bundle of the serial adder: start + operands in, status + result out.
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) ();

  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] S;
  logic             COUT;

  modport master (
    output START, A, B,
    input  BUSY, DONE, S, COUT
  );

  modport slave (
    input  START, A, B,
    output BUSY, DONE, S, COUT
  );

endinterface

// File: rtl/serial_adder_full_adder.sv
// 1-bit full adder built from two half-adder cells; the only arithmetic cell of the serial adder.
module half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;

endmodule

module full_adder (
  input  logic A,
  input  logic B,
  input  logic CI,
  output logic S,
  output logic CO
);

  logic w_s1;
  logic w_c1;
  logic w_c2;

  half_adder u_ha0 (
    .i_a (A),
    .i_b (B),
    .o_s (w_s1),
    .o_c (w_c1)
  );

  half_adder u_ha1 (
    .i_a (w_s1),
    .i_b (CI),
    .o_s (S),
    .o_c (w_c2)
  );

  assign CO = w_c1 | w_c2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first, one bit per clock through a single full adder and a carry flop.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic          CLK,
  input  logic          RST_N,
  serial_adder_if.slave bus
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic             w_load;
  logic             w_step;
  logic             w_busy;
  logic             w_done;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic             w_sum_bit;
  logic             w_carry;

  full_adder u_fa (
    .A  (r_a[0]),
    .B  (r_b[0]),
    .CI (r_carry),
    .S  (w_sum_bit),
    .CO (w_carry)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FIN accepts a new START exactly like IDLE, so back-to-back additions lose no cycle.
  always_comb begin
    w_next = IDLE;
    w_load = 1'b0;
    w_step = 1'b0;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.START) begin
          w_load = 1'b1;
          w_next = RUN;
        end
      end
      RUN: begin
        w_busy = 1'b1;
        w_step = 1'b1;
        w_next = (r_cnt == CNT_LAST) ? FIN : RUN;
      end
      FIN: begin
        w_done = 1'b1;
        if (bus.START) begin
          w_load = 1'b1;
          w_next = RUN;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
    end else if (w_load) begin
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_carry <= w_carry;
      r_sum   <= {w_sum_bit, r_sum[WIDTH-1:1]};
      if (r_cnt != CNT_LAST) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Operand shifters carry no reset: they are always reloaded before use.
  always_ff @(posedge CLK) begin
    if (w_load) begin
      r_a <= bus.A;
      r_b <= bus.B;
    end else if (w_step) begin
      r_a <= {1'b0, r_a[WIDTH-1:1]};
      r_b <= {1'b0, r_b[WIDTH-1:1]};
    end
  end

  assign bus.BUSY = w_busy;
  assign bus.DONE = w_done;
  assign bus.S    = r_sum;
  assign bus.COUT = r_carry;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: 8-bit and 16-bit instances checked against plain A+B.
module tb_serial_adder;
  import serial_adder_pkg::*;

  localparam int W8  = WIDTH_DEFAULT;
  localparam int W16 = 16;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(W8))  bus8 ();
  serial_adder_if #(.WIDTH(W16)) bus16 ();

  serial_adder #(.WIDTH(W8)) dut8 (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus8)
  );

  serial_adder #(.WIDTH(W16)) dut16 (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus16)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [W8:0]  exp8_q[$];
  logic [W16:0] exp16_q[$];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  // Monitors: every DONE pulse consumes one expected {COUT,S}.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus8.DONE === 1'b1) begin
      logic [W8:0] e;
      check("done8_not_busy", 64'(bus8.BUSY), 64'(0));
      check("done8_expected", 64'(exp8_q.size() != 0), 64'(1));
      if (exp8_q.size() != 0) begin
        e = exp8_q.pop_front();
        check("sum8", 64'({bus8.COUT, bus8.S}), 64'(e));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus16.DONE === 1'b1) begin
      logic [W16:0] e;
      check("done16_not_busy", 64'(bus16.BUSY), 64'(0));
      check("done16_expected", 64'(exp16_q.size() != 0), 64'(1));
      if (exp16_q.size() != 0) begin
        e = exp16_q.pop_front();
        check("sum16", 64'({bus16.COUT, bus16.S}), 64'(e));
      end
    end
  end

  // Issue one START at the current negedge, scramble operands afterwards, wait for DONE.
  task automatic run8(input logic [W8-1:0] a, input logic [W8-1:0] b);
    int cycles;
    bus8.A     = a;
    bus8.B     = b;
    bus8.START = 1'b1;
    exp8_q.push_back({1'b0, a} + {1'b0, b});
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) begin
        bus8.START = 1'b0;
        bus8.A     = W8'($urandom);
        bus8.B     = W8'($urandom);
      end
    end while (bus8.DONE !== 1'b1 && cycles < 64);
    check("latency8", 64'(cycles), 64'(W8 + 1));
  endtask

  task automatic run16(input logic [W16-1:0] a, input logic [W16-1:0] b);
    int cycles;
    bus16.A     = a;
    bus16.B     = b;
    bus16.START = 1'b1;
    exp16_q.push_back({1'b0, a} + {1'b0, b});
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) begin
        bus16.START = 1'b0;
        bus16.A     = W16'($urandom);
        bus16.B     = W16'($urandom);
      end
    end while (bus16.DONE !== 1'b1 && cycles < 64);
    check("latency16", 64'(cycles), 64'(W16 + 1));
  endtask

  task automatic sweep8(input int n);
    for (int i = 0; i < n; i++) begin
      run8(W8'($urandom), W8'($urandom));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 2)) @(negedge clk);
    end
  endtask

  task automatic sweep16(input int n);
    for (int i = 0; i < n; i++) begin
      run16(W16'($urandom), W16'($urandom));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 2)) @(negedge clk);
    end
  endtask

  initial begin
    int dones;
    int cyc;
    int last;

    rst_n       = 1'b0;
    bus8.START  = 1'b0;
    bus8.A      = '0;
    bus8.B      = '0;
    bus16.START = 1'b0;
    bus16.A     = '0;
    bus16.B     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy8", 64'(bus8.BUSY), 64'(0));
    check("rst_done8", 64'(bus8.DONE), 64'(0));
    check("rst_s8",    64'(bus8.S),    64'(0));
    check("rst_cout8", 64'(bus8.COUT), 64'(0));
    check("rst_s16",   64'(bus16.S),   64'(0));
    check("rst_busy16", 64'(bus16.BUSY), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // 5A + A5, then result must hold while idle
    run8(8'h5A, 8'hA5);
    repeat (3) @(negedge clk);
    check("hold_s",    64'(bus8.S),    64'(8'hFF));
    check("hold_cout", 64'(bus8.COUT), 64'(0));
    check("idle_busy", 64'(bus8.BUSY), 64'(0));

    // carry-out cases, the second one accepted straight from FIN
    run8(8'hFF, 8'h01);
    run8(8'hFF, 8'hFF);
    @(negedge clk);

    // reset wins over a simultaneous START and clears the held result
    rst_n      = 1'b0;
    bus8.START = 1'b1;
    @(negedge clk);
    rst_n      = 1'b1;
    bus8.START = 1'b0;
    check("rstprio_busy", 64'(bus8.BUSY), 64'(0));
    check("rstprio_s",    64'(bus8.S),    64'(0));
    check("rstprio_cout", 64'(bus8.COUT), 64'(0));
    @(negedge clk);
    check("rstprio_idle", 64'(bus8.BUSY), 64'(0));

    // START held high: back-to-back 1+2, operands scrambled while running
    bus8.A     = 8'h01;
    bus8.B     = 8'h02;
    bus8.START = 1'b1;
    repeat (3) exp8_q.push_back(9'h003);
    dones = 0;
    cyc   = 0;
    last  = 0;
    while (dones < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus8.DONE === 1'b1) begin
        dones++;
        check("b2b_period", 64'(cyc - last), 64'(W8 + 1));
        last   = cyc;
        bus8.A = 8'h01;
        bus8.B = 8'h02;
        if (dones == 3) bus8.START = 1'b0;
      end else begin
        bus8.A = W8'($urandom);
        bus8.B = W8'($urandom);
      end
    end
    check("b2b_count", 64'(dones), 64'(3));
    @(negedge clk);
    check("b2b_stop_busy", 64'(bus8.BUSY), 64'(0));

    // abort in RUN cycle 4: no DONE, everything cleared
    bus8.A     = 8'h80;
    bus8.B     = 8'h80;
    bus8.START = 1'b1;
    @(negedge clk);
    bus8.START = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_was_busy", 64'(bus8.BUSY), 64'(1));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", 64'(bus8.BUSY), 64'(0));
    check("abort_done", 64'(bus8.DONE), 64'(0));
    check("abort_s",    64'(bus8.S),    64'(0));
    check("abort_cout", 64'(bus8.COUT), 64'(0));
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus8.DONE === 1'b1) dones++;
    end
    check("abort_no_done", 64'(dones), 64'(0));
    run8(8'h10, 8'h20);
    @(negedge clk);

    fork
      sweep8(1000);
      sweep16(1000);
    join

    repeat (3) @(negedge clk);
    check("queue8_drained",  64'(exp8_q.size()),  64'(0));
    check("queue16_drained", 64'(exp16_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
